// File: rtl/mdu_issue_if.sv
// Upstream ID/EX -> MDU issue handshake.
// One instruction (op + rs/rt operands) per valid/ready beat.
interface mdu_issue_if #(
    parameter int DW  = 32,
    parameter int OPW = 5
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [DW-1:0]  in_a;
    logic [DW-1:0]  in_b;

    modport master (
        output in_valid, in_op, in_a, in_b,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        output in_ready
    );
endinterface

// File: rtl/mdu_issue_unit.sv
// E-stage one-entry issue buffer in front of the multiply/divide unit.
// Issues single-cycle op pulses and captures mfhi/mflo read data.
module mdu_issue_unit #(
    parameter int DW  = 32,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           int_exc_req,
    mdu_issue_if.slave     up,
    input  logic           mdu_busy,
    input  logic [DW-1:0]  mdu_result,
    output logic [OPW-1:0] mdu_op,
    output logic [DW-1:0]  mdu_a,
    output logic [DW-1:0]  mdu_b,
    output logic           res_valid,
    output logic [DW-1:0]  res_data
);

    localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
    localparam logic [OPW-1:0] OP_MULT  = OPW'(1);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(4);
    localparam logic [OPW-1:0] OP_MFHI  = OPW'(5);
    localparam logic [OPW-1:0] OP_MFLO  = OPW'(6);
    localparam logic [OPW-1:0] OP_MSUB  = OPW'(9);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    logic [OPW-1:0] buf_op;
    logic [DW-1:0]  buf_a;
    logic [DW-1:0]  buf_b;
    logic           last_start;
    logic           issue_ok;
    logic           accept;

    function automatic logic is_start(input logic [OPW-1:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV ||
               op == OP_DIVU || op == OP_MSUB;
    endfunction

    function automatic logic is_read(input logic [OPW-1:0] op);
        return op == OP_MFHI || op == OP_MFLO;
    endfunction

    // Codes beyond MSUB are undefined and behave as NOP.
    function automatic logic is_nop(input logic [OPW-1:0] op);
        return op == OP_NOP || op > OP_MSUB;
    endfunction

    // Issue gating; last_start masks the cycle before mdu_busy rises.
    always_comb begin
        issue_ok = (state == FULL) && !mdu_busy &&
                   !int_exc_req && !last_start;
        up.in_ready = !int_exc_req && (state == EMPTY || issue_ok);
        accept = up.in_valid && up.in_ready && !is_nop(up.in_op);
    end

    // Buffer FSM, single-cycle op pulse and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            buf_op     <= OP_NOP;
            buf_a      <= '0;
            buf_b      <= '0;
            mdu_op     <= OP_NOP;
            mdu_a      <= '0;
            mdu_b      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            last_start <= 1'b0;
        end else if (int_exc_req) begin
            state      <= EMPTY;
            buf_op     <= OP_NOP;
            buf_a      <= '0;
            buf_b      <= '0;
            mdu_op     <= OP_NOP;
            res_valid  <= 1'b0;
            last_start <= 1'b0;
        end else begin
            res_valid  <= is_read(mdu_op);
            if (is_read(mdu_op))
                res_data <= mdu_result;
            mdu_op     <= OP_NOP;
            last_start <= 1'b0;
            if (issue_ok) begin
                mdu_op     <= buf_op;
                mdu_a      <= buf_a;
                mdu_b      <= buf_b;
                last_start <= is_start(buf_op);
                state      <= EMPTY;
            end
            if (accept) begin
                buf_op <= up.in_op;
                buf_a  <= up.in_a;
                buf_b  <= up.in_b;
                state  <= FULL;
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_unit.sv
// Bench for mdu_issue_unit: behavioural MDU, queue-based
// reference model, directed scenarios then random traffic.
module tb_mdu_issue_unit;

    logic        clk;
    logic        reset;
    logic        int_exc_req;
    logic        mdu_busy;
    logic [31:0] mdu_result;
    logic [4:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        res_valid;
    logic [31:0] res_data;

    mdu_issue_if #(.DW(32), .OPW(5)) bus ();

    mdu_issue_unit #(.DW(32), .OPW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .int_exc_req (int_exc_req),
        .up          (bus.slave),
        .mdu_busy    (mdu_busy),
        .mdu_result  (mdu_result),
        .mdu_op      (mdu_op),
        .mdu_a       (mdu_a),
        .mdu_b       (mdu_b),
        .res_valid   (res_valid),
        .res_data    (res_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Behavioural MDU: hi/lo registers, busy for busy_len cycles
    // starting the cycle after it sees a start op.
    int          busy_len = 5;
    int          cnt;
    logic [31:0] hi;
    logic [31:0] lo;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            if (cnt != 0) cnt <= cnt - 1;
            case (mdu_op)
                5'd1: begin {hi, lo} <= smul(mdu_a, mdu_b); cnt <= busy_len; end
                5'd2: begin {hi, lo} <= {32'd0, mdu_a} * {32'd0, mdu_b}; cnt <= busy_len; end
                5'd3: begin
                    if (mdu_b == 0) begin hi <= mdu_a; lo <= '1; end
                    else begin
                        lo <= $signed(mdu_a) / $signed(mdu_b);
                        hi <= $signed(mdu_a) % $signed(mdu_b);
                    end
                    cnt <= busy_len;
                end
                5'd4: begin
                    if (mdu_b == 0) begin hi <= mdu_a; lo <= '1; end
                    else begin lo <= mdu_a / mdu_b; hi <= mdu_a % mdu_b; end
                    cnt <= busy_len;
                end
                5'd7: hi <= mdu_a;
                5'd8: lo <= mdu_a;
                5'd9: begin {hi, lo} <= {hi, lo} - smul(mdu_a, mdu_b); cnt <= busy_len; end
                default: ;
            endcase
        end
    end

    assign mdu_busy   = (cnt != 0);
    assign mdu_result = (mdu_op == 5'd5) ? hi : lo;

    // Reference model state
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t        pend[$];
    logic [4:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_rv;
    logic [31:0] m_rd;
    logic        m_ls;
    logic [4:0]  prev_op;
    logic        last_rv;

    function automatic logic isst(input logic [4:0] op);
        return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
    endfunction

    function automatic logic isrd(input logic [4:0] op);
        return op == 5'd5 || op == 5'd6;
    endfunction

    function automatic logic nopc(input logic [4:0] op);
        return op == 5'd0 || op > 5'd9;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check ready, model, check outputs.
    task automatic step(input logic v, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exc, output logic acc);
        ent_t        e;
        logic        can;
        logic        rdy;
        logic [4:0]  n_op;
        logic [31:0] n_a;
        logic [31:0] n_b;
        logic [31:0] n_rd;
        logic        n_rv;
        logic        n_ls;
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        int_exc_req  = exc;
        #1;
        can = pend.size() != 0 && !mdu_busy && !exc && !m_ls;
        rdy = !exc && (pend.size() == 0 || can);
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        acc  = v && rdy && !nopc(op);
        n_op = 5'd0;
        n_a  = m_a;
        n_b  = m_b;
        n_rv = 1'b0;
        n_rd = m_rd;
        n_ls = 1'b0;
        if (exc) begin
            pend.delete();
        end else begin
            n_rv = isrd(m_op);
            if (n_rv) n_rd = mdu_result;
            if (can) begin
                e    = pend.pop_front();
                n_op = e.op;
                n_a  = e.a;
                n_b  = e.b;
                n_ls = isst(e.op);
            end
            if (acc) begin
                e.op = op;
                e.a  = a;
                e.b  = b;
                pend.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        m_op = n_op;
        m_a  = n_a;
        m_b  = n_b;
        m_rv = n_rv;
        m_rd = n_rd;
        m_ls = n_ls;
        chk("mdu_op", 32'(mdu_op), 32'(m_op));
        chk("mdu_a", mdu_a, m_a);
        chk("mdu_b", mdu_b, m_b);
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("res_data", res_data, m_rd);
        if (isst(prev_op))
            chk("op_after_start", 32'(mdu_op != 0), 32'd0);
        prev_op = mdu_op;
        last_rv = res_valid;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, acc);
    endtask

    task automatic do_reset(input logic exc);
        reset        = 1'b1;
        int_exc_req  = exc;
        bus.in_valid = 1'b1;
        bus.in_op    = 5'd1;
        @(posedge clk);
        #1;
        pend.delete();
        m_op = '0; m_a = '0; m_b = '0;
        m_rv = 1'b0; m_rd = '0; m_ls = 1'b0;
        prev_op = '0;
        last_rv = 1'b0;
        chk("rst_mdu_op", 32'(mdu_op), 32'd0);
        chk("rst_mdu_a", mdu_a, 32'd0);
        chk("rst_mdu_b", mdu_b, 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        reset        = 1'b0;
        int_exc_req  = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   held;
        int   rvc;
        reset        = 1'b1;
        int_exc_req  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        prev_op      = '0;
        @(negedge clk);
        do_reset(1'b0);

        // MTLO then MFLO back to back
        step(1'b1, 5'd8, 32'h1234, 32'd0, 1'b0, acc);
        step(1'b1, 5'd6, 32'd0, 32'd0, 1'b0, acc);
        chk("t1_mtlo_issue", 32'(mdu_op), 32'd8);
        idle(1);
        chk("t1_mflo_issue", 32'(mdu_op), 32'd6);
        idle(1);
        chk("t1_rv", 32'(res_valid), 32'd1);
        chk("t1_rd", res_data, 32'h1234);
        idle(2);

        // MULT 3 * -2 followed by MFLO, MTHI stalled behind it
        busy_len = 5;
        step(1'b1, 5'd1, 32'd3, 32'hFFFF_FFFE, 1'b0, acc);
        step(1'b1, 5'd6, 32'd0, 32'd0, 1'b0, acc);
        held = 0;
        acc  = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            step(1'b1, 5'd7, 32'hAAAA_0000, 32'd0, 1'b0, acc);
            if (!acc) held++;
        end
        chk("t2_accepted", 32'(acc), 32'd1);
        chk("t2_held", 32'(held >= 5), 32'd1);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (last_rv) break;
        end
        chk("t2_rv", 32'(last_rv), 32'd1);
        chk("t2_rd", res_data, 32'hFFFF_FFFA);
        idle(3);

        // DIV then DIVU back to back
        step(1'b1, 5'd3, 32'd100, 32'd7, 1'b0, acc);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++)
            step(1'b1, 5'd4, 32'd200, 32'd9, 1'b0, acc);
        chk("t3_divu_acc", 32'(acc), 32'd1);
        idle(10);

        // Flush while MFHI waits on a busy MDU
        step(1'b1, 5'd1, 32'd5, 32'd6, 1'b0, acc);
        step(1'b1, 5'd5, 32'd0, 32'd0, 1'b0, acc);
        idle(2);
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, acc);
        rvc = 0;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            if (last_rv) rvc++;
        end
        chk("t4_no_rv", 32'(rvc), 32'd0);
        step(1'b1, 5'd8, 32'h55, 32'd0, 1'b0, acc);
        chk("t4_post_acc", 32'(acc), 32'd1);
        step(1'b1, 5'd6, 32'd0, 32'd0, 1'b0, acc);
        idle(2);
        chk("t4_rd", res_data, 32'h55);

        // NOP and undefined code 20 are dropped
        step(1'b1, 5'd0, 32'd1, 32'd2, 1'b0, acc);
        step(1'b1, 5'd20, 32'd1, 32'd2, 1'b0, acc);
        chk("t5_nop_op", 32'(mdu_op), 32'd0);
        idle(1);
        chk("t5_nop_op2", 32'(mdu_op), 32'd0);

        // Reset mid-operation, with a flush request also present
        step(1'b1, 5'd1, 32'd7, 32'd8, 1'b0, acc);
        step(1'b1, 5'd6, 32'd0, 32'd0, 1'b0, acc);
        chk("t6_mult_on_bus", 32'(mdu_op), 32'd1);
        do_reset(1'b1);
        idle(2);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            busy_len = $urandom_range(1, 4);
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 12)),
                 $urandom, $urandom, $urandom_range(0, 19) == 0, acc);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
